joybus_tx: RTL

- Console-side Joybus command transmitter; sits directly upstream of the Joybus receiver.
- Serializes a 1–24 bit command (N64/GC encoding) plus console stop bit onto the open-drain line.
- Then watches the line for the controller's first falling edge and pulses rx_start, so the receiver's bit window aligns with the reply.
- Reports a timeout if the controller never answers.

---
 rtl/joybus_pkg.sv | 21 ++
 rtl/joybus_sync.sv | 26 ++
 rtl/joybus_tx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/joybus_pkg.sv
// Shared Joybus definitions: transmitter states, command constants, timing defaults.
package joybus_pkg;

  localparam int JB_CYC_PER_US_DEFAULT  = 25;
  localparam int JB_TIMEOUT_CYC_DEFAULT = 2500;
  localparam int JB_MAX_BITS            = 24;

  localparam logic [7:0]  JB_CMD_N64_INFO = 8'h00;
  localparam logic [7:0]  JB_CMD_N64_POLL = 8'h01;
  localparam logic [23:0] JB_CMD_GC_POLL  = 24'h400302;

  typedef enum logic [2:0] {
    IDLE,
    BIT_LO,
    BIT_HI,
    STOP_LO,
    WAIT_HI,
    WAIT_EDGE
  } jb_tx_state_e;

endpackage

// File: rtl/joybus_sync.sv
// Two-flop synchronizer for the raw Joybus line; idles high like the pulled-up line.
module joybus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Two-stage capture of the asynchronous line, reset to the released (high) level.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make s2_q take the old s1_q, giving two real stages.
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/joybus_tx.sv
// Console-side Joybus command transmitter: sends a 0-24 bit command plus stop bit,
// then waits for the controller's first falling edge and pulses rx_start.
// Optional macro JOYBUS_TX_COLLISION_EN: abort the frame when the line is found low
// at the end of a bit's high phase.
module joybus_tx
  import joybus_pkg::*;
#(
  parameter int CYC_PER_US  = JB_CYC_PER_US_DEFAULT,
  parameter int TIMEOUT_CYC = JB_TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic [23:0] tx_data,
  input  logic [4:0]  tx_len,
  input  logic        JB_RX,
  output logic        JB_TX_OE,
  output logic        tx_busy,
  output logic        rx_start,
  output logic        tx_done,
  output logic        tx_timeout,
  output logic        tx_collision
);

  localparam int CNT_W = $clog2(4 * CYC_PER_US);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  // Phase counters hold "cycles remaining minus one" so a phase ends when they read zero.
  localparam logic [CNT_W-1:0] LO_ONE   = CNT_W'(CYC_PER_US - 1);
  localparam logic [CNT_W-1:0] LO_ZERO  = CNT_W'(3 * CYC_PER_US - 1);
  localparam logic [CNT_W-1:0] HI_ONE   = CNT_W'(3 * CYC_PER_US - 1);
  localparam logic [CNT_W-1:0] HI_ZERO  = CNT_W'(CYC_PER_US - 1);
  localparam logic [CNT_W-1:0] STOP_LEN = CNT_W'(CYC_PER_US - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic rx_s;

  joybus_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (JB_RX),
    .q     (rx_s)
  );

  jb_tx_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [4:0]       bits_q, bits_d;
  logic [23:0]      shreg_q, shreg_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             rx_start_q, rx_start_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             coll_q, coll_d;
  logic             collide;

  // Next-state, counter and registered-output computation for the frame sequencer.
  always_comb begin
    // NOTE: every variable gets a default here so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    bits_d     = bits_q;
    shreg_d    = shreg_q;
    oe_d       = oe_q;
    rx_start_d = 1'b0;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    coll_d     = 1'b0;
    collide    = 1'b0;
`ifdef JOYBUS_TX_COLLISION_EN
    collide    = !rx_s;
`endif

    case (state_q)
      IDLE: begin
        oe_d = 1'b0;
        if (tx_start) begin
          shreg_d = tx_data;
          bits_d  = (tx_len > 5'd24) ? 5'd24 : tx_len;
          oe_d    = 1'b1;
          if (bits_d == 5'd0) begin
            state_d = STOP_LO;
            cnt_d   = STOP_LEN;
          end else begin
            state_d = BIT_LO;
            cnt_d   = tx_data[23] ? LO_ONE : LO_ZERO;
          end
        end
      end

      BIT_LO: begin
        if (cnt_q == '0) begin
          state_d = BIT_HI;
          oe_d    = 1'b0;
          cnt_d   = shreg_q[23] ? HI_ONE : HI_ZERO;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      BIT_HI: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (collide) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          coll_d  = 1'b1;
        end else begin
          shreg_d = {shreg_q[22:0], 1'b0};
          bits_d  = bits_q - 5'd1;
          oe_d    = 1'b1;
          if (bits_q == 5'd1) begin
            state_d = STOP_LO;
            cnt_d   = STOP_LEN;
          end else begin
            state_d = BIT_LO;
            cnt_d   = shreg_q[22] ? LO_ONE : LO_ZERO;
          end
        end
      end

      STOP_LO: begin
        if (cnt_q == '0) begin
          state_d = WAIT_HI;
          oe_d    = 1'b0;
          tmo_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // Line must first read high so the synchronizer lag after our stop bit is not taken as a reply.
      WAIT_HI: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == TMO_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (rx_s) begin
          state_d = WAIT_EDGE;
        end
      end

      // A reply edge takes priority over a timeout landing in the same cycle.
      WAIT_EDGE: begin
        tmo_d = tmo_q + 1'b1;
        if (!rx_s) begin
          state_d    = IDLE;
          rx_start_d = 1'b1;
          done_d     = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        oe_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Sequencer state and registered outputs; reset releases the line immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tmo_q      <= '0;
      bits_q     <= '0;
      shreg_q    <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_start_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      bits_q     <= bits_d;
      shreg_q    <= shreg_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      rx_start_q <= rx_start_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      coll_q     <= coll_d;
    end
  end

  assign JB_TX_OE     = oe_q;
  assign tx_busy      = busy_q;
  assign rx_start     = rx_start_q;
  assign tx_done      = done_q;
  assign tx_timeout   = timeout_q;
  assign tx_collision = coll_q;

endmodule
